control_unit: RTL and testbench

- Main decoder of the single-issue RISC-V (RV32I subset) datapath.
- Maps the 7-bit instruction opcode to the datapath control signals: ALU operand select, write-back select, register-file write, data-memory read/write, branch and ALU-operation class.
- Outputs are registered, giving one cycle of latency.
- Sits between instruction fetch/decode and the datapath; ALUOp feeds the downstream ALU-control decoder.

---
 rtl/riscv_pkg.sv | 42 ++++
 rtl/control_decode.sv | 44 ++++
 rtl/control_unit.sv | 44 ++++
 tb/tb_control_unit.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcode constants, ALU class encodings and
// the control bundle passed from the decoder to the output register.
package riscv_pkg;

    localparam int OP_W = 7;

    localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
    localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD = 2'b00,
        ALUOP_SUB = 2'b01,
        ALUOP_R   = 2'b10,
        ALUOP_I   = 2'b11
    } aluop_e;

    typedef struct packed {
        logic   alu_src;
        logic   mem_to_reg;
        logic   reg_write;
        logic   mem_read;
        logic   mem_write;
        logic   branch;
        aluop_e alu_op;
        logic   illegal_op;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '{
        alu_src:    1'b0,
        mem_to_reg: 1'b0,
        reg_write:  1'b0,
        mem_read:   1'b0,
        mem_write:  1'b0,
        branch:     1'b0,
        alu_op:     ALUOP_ADD,
        illegal_op: 1'b0
    };

endpackage

// File: rtl/control_decode.sv
// Purely combinational opcode-to-control decode; unsupported opcodes
// produce an all-zero bundle with only illegal_op set.
module control_decode
    import riscv_pkg::*;
(
    input  logic [OP_W-1:0] op,
    output ctrl_t           ctrl
);

    always_comb begin
        ctrl = CTRL_NOP;
        case (op)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_R;
            end
            OP_ITYPE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALUOP_I;
            end
            OP_LOAD: begin
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_op     = ALUOP_ADD;
            end
            OP_STORE: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_op    = ALUOP_ADD;
            end
            OP_BRANCH: begin
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALUOP_SUB;
            end
            default: begin
                ctrl.illegal_op = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Main decoder: registers the combinational decode so every control output
// appears one cycle after its opcode is sampled; async reset clears all.
module control_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    output logic            ALUSrc,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            Branch,
    output logic [1:0]      ALUOp,
    output logic            illegal_op
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .op   (op),
        .ctrl (ctrl_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= CTRL_NOP;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign ALUSrc     = ctrl_q.alu_src;
    assign MemtoReg   = ctrl_q.mem_to_reg;
    assign RegWrite   = ctrl_q.reg_write;
    assign MemRead    = ctrl_q.mem_read;
    assign MemWrite   = ctrl_q.mem_write;
    assign Branch     = ctrl_q.branch;
    assign ALUOp      = ctrl_q.alu_op;
    assign illegal_op = ctrl_q.illegal_op;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: expected control vectors are queued
// when an opcode is driven and compared one rising edge later.
module tb_control_unit;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, illegal_op;
    logic [1:0] ALUOp;

    // {ALUSrc MemtoReg RegWrite MemRead MemWrite Branch ALUOp[1:0] illegal_op}
    logic [8:0] obs;
    logic [8:0] sb_q[$];
    logic [8:0] exp_v;
    logic [8:0] prev_v;
    int errors = 0;
    int checks = 0;

    localparam logic [8:0] V_ZERO   = 9'b000000_00_0;
    localparam logic [8:0] V_RTYPE  = 9'b001000_10_0;
    localparam logic [8:0] V_ITYPE  = 9'b101000_11_0;
    localparam logic [8:0] V_LOAD   = 9'b111100_00_0;
    localparam logic [8:0] V_STORE  = 9'b100010_00_0;
    localparam logic [8:0] V_BRANCH = 9'b000001_01_0;
    localparam logic [8:0] V_ILLEGAL = 9'b000000_00_1;

    control_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Branch     (Branch),
        .ALUOp      (ALUOp),
        .illegal_op (illegal_op)
    );

    assign obs = {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] ref_decode(input logic [6:0] opc);
        case (opc)
            7'b0110011: return V_RTYPE;
            7'b0010011: return V_ITYPE;
            7'b0000011: return V_LOAD;
            7'b0100011: return V_STORE;
            7'b1100011: return V_BRANCH;
            default:    return V_ILLEGAL;
        endcase
    endfunction

    // Drive an opcode on the falling edge and queue its expected result.
    task automatic drive_op(input logic [6:0] opc, input logic [8:0] expv);
        @(negedge clk);
        op = opc;
        sb_q.push_back(expv);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        op    = 7'b0110011;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_ZERO) begin
            errors++;
            $display("FAIL reset_immediate got=%b want=%b", obs, V_ZERO);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (obs !== V_ZERO) begin
                errors++;
                $display("FAIL reset_held cyc=%0d got=%b want=%b", i, obs, V_ZERO);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(V_RTYPE);
        #1;
        checks++;
        if (obs !== V_ZERO) begin
            errors++;
            $display("FAIL reset_release_before_edge got=%b want=%b", obs, V_ZERO);
        end
        @(posedge clk); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_first_edge got=%b want=%b", obs, exp_v);
        end
        $display("test_reset done op=0110011 obs=%b", obs);
    endtask

    task automatic test_rtype();
        drive_op(7'b0110011, V_RTYPE);
        @(posedge clk); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL rtype got=%b want=%b", obs, exp_v);
        end
        $display("test_rtype op=0110011 obs=%b", obs);
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops [3];
        logic [8:0] vals[3];
        ops[0] = 7'b0000011; vals[0] = V_LOAD;
        ops[1] = 7'b0100011; vals[1] = V_STORE;
        ops[2] = 7'b1100011; vals[2] = V_BRANCH;
        prev_v = obs;
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], vals[i]);
            #1;
            checks++;
            if (obs !== prev_v) begin
                errors++;
                $display("FAIL b2b_early idx=%0d got=%b want=%b", i, obs, prev_v);
            end
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL b2b idx=%0d op=%b got=%b want=%b", i, ops[i], obs, exp_v);
            end
            $display("test_back_to_back op=%b obs=%b", ops[i], obs);
            prev_v = exp_v;
        end
    endtask

    task automatic test_itype_illegal();
        logic [6:0] ops [3];
        logic [8:0] vals[3];
        ops[0] = 7'b0010011; vals[0] = V_ITYPE;
        ops[1] = 7'b0000000; vals[1] = V_ILLEGAL;
        ops[2] = 7'b1111111; vals[2] = V_ILLEGAL;
        for (int i = 0; i < 3; i++) begin
            drive_op(ops[i], vals[i]);
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL itype_illegal op=%b got=%b want=%b", ops[i], obs, exp_v);
            end
            $display("test_itype_illegal op=%b obs=%b", ops[i], obs);
        end
    endtask

    task automatic test_async_reset();
        drive_op(7'b0000011, V_LOAD);
        @(posedge clk); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_pre got=%b want=%b", obs, exp_v);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== V_ZERO) begin
            errors++;
            $display("FAIL async_drop got=%b want=%b", obs, V_ZERO);
        end
        @(posedge clk); #1;
        checks++;
        if (obs !== V_ZERO) begin
            errors++;
            $display("FAIL async_held got=%b want=%b", obs, V_ZERO);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(V_LOAD);
        #1;
        checks++;
        if (obs !== V_ZERO) begin
            errors++;
            $display("FAIL async_release_before_edge got=%b want=%b", obs, V_ZERO);
        end
        @(posedge clk); #1;
        exp_v = sb_q.pop_front();
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_first_edge got=%b want=%b", obs, exp_v);
        end
        $display("test_async_reset op=0000011 obs=%b", obs);
    endtask

    task automatic test_sweep();
        int n_illegal = 0;
        logic [6:0] opc;
        for (int i = 0; i < 128; i++) begin
            opc = 7'(i);
            drive_op(opc, ref_decode(opc));
            @(posedge clk); #1;
            exp_v = sb_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL sweep op=%b got=%b want=%b", opc, obs, exp_v);
            end
            checks++;
            if ((MemRead && MemWrite) || ((MemWrite || Branch) && RegWrite) ||
                (illegal_op && (ALUSrc || MemtoReg || RegWrite || MemRead || MemWrite || Branch || ALUOp != 2'b00))) begin
                errors++;
                $display("FAIL sweep_invariant op=%b got=%b want=consistent", opc, obs);
            end
            if (illegal_op === 1'b1) n_illegal++;
            $display("test_sweep op=%b obs=%b", opc, obs);
        end
        checks++;
        if (n_illegal != 123) begin
            errors++;
            $display("FAIL sweep_illegal_count got=%0d want=123", n_illegal);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_back_to_back();
        test_itype_illegal();
        test_async_reset();
        test_sweep();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "timeout");
    end

endmodule
